// File: rtl/fp_mult_pipe_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand classes, flag bit positions and width-generic helpers.
package fp_mult_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_INF  = 2'd1,
    CLS_NAN  = 2'd2,
    CLS_NORM = 2'd3
  } fp_class_e;

  localparam int unsigned FLAG_INVALID   = 2;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 0;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Denormals (exp == 0, frac != 0) deliberately classify as zero (flush-to-zero).
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_norm_round.sv
// Combinational normalise plus round-to-nearest-even of the raw mantissa
// product; a rounding carry-out renormalises into the exponent.
module fp_norm_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [2*(MAN_W+1)-1:0] prod,
  input  logic signed [EXP_W+1:0] esum_in,
  output logic [MAN_W-1:0]        frac,
  output logic signed [EXP_W+1:0] esum_out
);

  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;

  logic [PW-2:0]          norm;
  logic signed [EW-1:0]   esum_n;
  logic                   lsb;
  logic                   guard;
  logic                   sticky;
  logic [MAN_W:0]         rounded;

  always_comb begin
    // The leading one sits at PW-1 or PW-2; drop it after aligning to PW-1.
    norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    esum_n   = prod[PW-1] ? esum_in + EW'(1) : esum_in;
    lsb      = norm[MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    rounded  = {1'b0, norm[PW-2 -: MAN_W]} + (MAN_W+1)'(guard & (sticky | lsb));
    frac     = rounded[MAN_W-1:0];
    esum_out = esum_n + EW'(rounded[MAN_W]);
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control: classify/multiply, normalise/round, special-case pack.
module fp_mult_pipe
  import fp_mult_pipe_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam int unsigned XLEN = 1 + EXP_W + MAN_W;
  localparam int unsigned PW   = 2 * (MAN_W + 1);
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = fp_bias(EXP_W);

  localparam logic signed [EW-1:0] ESUM_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ESUM_ONE = EW'(1);
  localparam logic [XLEN-1:0]      QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;

  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     frac_a, frac_b;
  fp_class_e            cls_a_c, cls_b_c;
  logic signed [EW-1:0] esum_c;
  logic [PW-1:0]        prod_c;

  logic                 s1_valid, s1_sign;
  logic signed [EW-1:0] s1_esum;
  logic [PW-1:0]        s1_prod;
  fp_class_e            s1_cls_a, s1_cls_b;

  logic [MAN_W-1:0]     nr_frac;
  logic signed [EW-1:0] nr_esum;

  logic                 s2_valid, s2_sign;
  logic signed [EW-1:0] s2_esum;
  logic [MAN_W-1:0]     s2_frac;
  fp_class_e            s2_cls_a, s2_cls_b;

  logic [XLEN-1:0]      pack_res;
  logic [2:0]           pack_flags;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    exp_a   = A[XLEN-2 -: EXP_W];
    exp_b   = B[XLEN-2 -: EXP_W];
    frac_a  = A[MAN_W-1:0];
    frac_b  = B[MAN_W-1:0];
    cls_a_c = fp_classify(exp_a == '0, exp_a == '1, frac_a == '0);
    cls_b_c = fp_classify(exp_b == '0, exp_b == '1, frac_b == '0);
    esum_c  = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
    prod_c  = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
  end

  fp_norm_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_norm_round (
    .prod    (s1_prod),
    .esum_in (s1_esum),
    .frac    (nr_frac),
    .esum_out(nr_esum)
  );

  always_comb begin
    pack_res   = {s2_sign, s2_esum[EXP_W-1:0], s2_frac};
    pack_flags = '0;
    if (s2_cls_a == CLS_NAN || s2_cls_b == CLS_NAN ||
        (s2_cls_a == CLS_INF && s2_cls_b == CLS_ZERO) ||
        (s2_cls_a == CLS_ZERO && s2_cls_b == CLS_INF)) begin
      pack_res                 = QNAN;
      pack_flags[FLAG_INVALID] = 1'b1;
    end else if (s2_cls_a == CLS_INF || s2_cls_b == CLS_INF) begin
      pack_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_cls_a == CLS_ZERO || s2_cls_b == CLS_ZERO) begin
      pack_res = {s2_sign, {(XLEN-1){1'b0}}};
    end else if (s2_esum >= ESUM_MAX) begin
      pack_res                  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pack_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (s2_esum < ESUM_ONE) begin
      pack_res                   = {s2_sign, {(XLEN-1){1'b0}}};
      pack_flags[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_esum   <= '0;
      s1_prod   <= '0;
      s1_cls_a  <= CLS_ZERO;
      s1_cls_b  <= CLS_ZERO;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_esum   <= '0;
      s2_frac   <= '0;
      s2_cls_a  <= CLS_ZERO;
      s2_cls_b  <= CLS_ZERO;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= A[XLEN-1] ^ B[XLEN-1];
      s1_esum   <= esum_c;
      s1_prod   <= prod_c;
      s1_cls_a  <= cls_a_c;
      s1_cls_b  <= cls_b_c;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_esum   <= nr_esum;
      s2_frac   <= nr_frac;
      s2_cls_a  <= s1_cls_a;
      s2_cls_b  <= s1_cls_b;
      out_valid <= s2_valid;
      // Bubbles leave the last result on the output rather than packing junk.
      if (s2_valid) begin
        result <= pack_res;
        flags  <= pack_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Randomised and directed bench for fp_mult_pipe (binary32) against an
// integer-arithmetic reference model with an in-order scoreboard.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned n_out = 0;
  int unsigned last_acc_edge = 0;
  int unsigned last_out_edge = 0;
  logic [31:0] last_res;
  logic [2:0]  last_flags;

  logic [34:0] sb[$];
  bit          was_stall = 0;
  logic [31:0] held_res;
  logic [2:0]  held_flags;

  fp_mult_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {flags, result}; rounding done by integer quotient/remainder.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, sh;
    longint fa, fb, p, q, r, half;
    bit     s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    p = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
    if (p >= (64'd1 << 47)) begin sh = 24; e = ea + eb - 126; end
    else begin sh = 23; e = ea + eb - 127; end
    q    = p >> sh;
    r    = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       begin e = 8'hFF; f = '0; end
      3:       e = 8'($urandom_range(1, 20));
      4:       e = 8'($urandom_range(230, 254));
      5:       begin e = 8'($urandom_range(1, 254)); f = '1; end
      6:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard and handshake-rule checker; sampled on the falling edge,
  // so everything seen here is what the next rising edge will act on.
  always @(negedge clk) begin
    logic [34:0] exp_v;
    if (!rst_n) begin
      sb.delete();
      was_stall = 0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (was_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_result", 64'(result), 64'(held_res));
        check("stall_flags", 64'(flags), 64'(held_flags));
      end
      was_stall  = out_valid && !out_ready;
      held_res   = result;
      held_flags = flags;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          exp_v = sb.pop_front();
          check("result", 64'(result), 64'(exp_v[31:0]));
          check("flags", 64'(flags), 64'(exp_v[34:32]));
        end
        last_res      = result;
        last_flags    = flags;
        last_out_edge = cyc + 1;
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(A, B));
        last_acc_edge = cyc + 1;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int unsigned n = 0;
    bit          done = 0;
    A = a; B = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        check("accept_timeout", 64'(in_ready), 64'd1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [2:0] ef);
    int unsigned n0 = n_out;
    bit          got = 0;
    check({"model_", name}, 64'(model(a, b)), 64'({ef, er}));
    send(a, b);
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      got = (n_out != n0);
    end
    #1;
    check({name, "_emitted"}, 64'(got), 64'd1);
    check({name, "_result"}, 64'(last_res), 64'(er));
    check({name, "_flags"}, 64'(last_flags), 64'(ef));
    check({name, "_latency"}, 64'(last_out_edge - last_acc_edge), 64'd3);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run_one("neg_half_x4", 32'hBF000000, 32'h40800000, 32'hC0000000, 3'b000);
    run_one("round_up",    32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run_one("tie_even",    32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000);
    run_one("carry_out",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000);
    run_one("overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
    run_one("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
    run_one("denorm_ftz",  32'h00400000, 32'h40000000, 32'h00000000, 3'b000);
    run_one("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    run_one("neg_inf",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
    run_one("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
    run_one("neg_zero",    32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);

    // Back-to-back stream with a 5-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++) send(gen_operand(), gen_operand());
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream");

    // Reset with three items in flight: none of them may emerge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(gen_operand(), gen_operand());
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    run_one("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);

    // Randomised traffic with random producer and consumer pacing.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      A = gen_operand();
      B = gen_operand();
      @(posedge clk); #1;
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
